mod_mul_ctrl: RTL

Front end that produces the 128-bit operand for the Barrett 128→64 modular reduction unit and drives its enable/valid handshake as initiator. It latches two 64-bit operands, forms their exact 128-bit unsigned product with an iterative radix-2 shift-add multiplier, and pulses the reducer's enable. It then waits for the reducer's valid and returns the 64-bit reduced result to the ECC point-arithmetic sequencer. It is the requesting end of the reducer interface: the reducer consumes `a`/`sign`/`enable` and answers with `valid`/`result`.

---
 rtl/mod_mul_ctrl_if.sv | 25 ++
 rtl/mod_mul_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mod_mul_ctrl_if.sv
// Handshake between the modular-multiply front end (master) and the Barrett reducer (slave).
// The master drives the 128-bit operand, sign and enable; the slave answers with valid/result.
interface mod_mul_ctrl_if;
    logic         red_enable;
    logic [127:0] red_a;
    logic         red_sign;
    logic         red_valid;
    logic [63:0]  red_result;

    modport master (
        output red_enable,
        output red_a,
        output red_sign,
        input  red_valid,
        input  red_result
    );

    modport slave (
        input  red_enable,
        input  red_a,
        input  red_sign,
        output red_valid,
        output red_result
    );
endinterface

// File: rtl/mod_mul_ctrl.sv
// Latches two 64-bit operands, forms their 128-bit product with a radix-2 shift-add loop,
// hands it to the Barrett reducer and returns the reduced value with done/err pulses.
module mod_mul_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [63:0]           op_a_i,
    input  logic [63:0]           op_b_i,
    input  logic                  neg_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [63:0]           result_o,
    mod_mul_ctrl_if.master        red
);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StReq,
        StWait,
        StFin
    } state_e;

    state_e state_q, state_d;

    logic [63:0]  op_a_q, op_a_d;
    logic [63:0]  op_b_q, op_b_d;
    logic [127:0] acc_q, acc_d;
    logic [5:0]   bit_cnt_q, bit_cnt_d;
    logic [15:0]  wait_cnt_q, wait_cnt_d;
    logic         sign_q, sign_d;
    logic [63:0]  result_q, result_d;
    logic         err_q, err_d;

    logic         accept;
    logic         last_bit;
    logic         timeout;
    logic [127:0] partial;

    assign accept   = (state_q == StIdle) && start_i;
    assign last_bit = (bit_cnt_q == 6'd63);
    // Counter equals TIMEOUT_CYC-1 on the last of TIMEOUT_CYC WAIT cycles.
    assign timeout  = (wait_cnt_q == 16'(TIMEOUT_CYC - 1));
    assign partial  = {64'b0, op_a_q} << bit_cnt_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StMul;
                end
            end
            StMul: begin
                if (last_bit) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                state_d = StWait;
            end
            StWait: begin
                if (red.red_valid) begin
                    state_d = StFin;
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy_o         = (state_q != StIdle);
        done_o         = (state_q == StFin);
        err_o          = err_q;
        result_o       = result_q;
        red.red_enable = (state_q == StReq);
        red.red_a      = acc_q;
        red.red_sign   = sign_q;
    end

    // Datapath next-state.
    always_comb begin
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        sign_d     = sign_q;
        result_d   = result_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_a_d    = op_a_i;
                    op_b_d    = op_b_i;
                    sign_d    = neg_i;
                    acc_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            StMul: begin
                if (op_b_q[bit_cnt_q]) begin
                    acc_d = acc_q + partial;
                end
                bit_cnt_d = bit_cnt_q + 6'd1;
            end
            StReq: begin
                wait_cnt_d = '0;
            end
            StWait: begin
                // The reducer's valid is a level; any value seen before WAIT is stale.
                if (red.red_valid) begin
                    result_d = red.red_result;
                end else if (timeout) begin
                    err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            StFin: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            sign_q     <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            acc_q      <= acc_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            sign_q     <= sign_d;
            result_q   <= result_d;
            err_q      <= err_d;
        end
    end

endmodule
